// File: rtl/text_write_arbiter.sv
// text_write_arbiter: shares the single write port of the text display
// between a character stream (cursor-relative, control-code aware) and a
// status writer (absolute positions). Also owns the terminal cursor and
// runs the full-screen blank fill.
module text_write_arbiter #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       stat_valid,
  input  logic [6:0] stat_x,
  input  logic [4:0] stat_y,
  input  logic [6:0] stat_data,
  output logic       stat_ready,
  input  logic       clear_req,
  input  logic       buf_busy,
  output logic       write_enable,
  output logic [6:0] write_x,
  output logic [4:0] write_y,
  output logic [6:0] write_data,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       clearing
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_CLEAR
  } state_t;

  state_t     state;
  logic       last_grant_stat;  // 1: status was granted last, so char wins a tie
  logic [6:0] fill_x;
  logic [4:0] fill_y;
  logic       fill_last;        // the strobe in flight is the final fill cell

  logic       idle_free;
  logic       grant_char;
  logic       grant_stat;

  // Grant decision: only in IDLE with the display free and no clear pending;
  // ties go to whichever requester was not served last. Gated by reset_n so
  // the readies are low while reset is held.
  always_comb begin
    idle_free  = reset_n && (state == S_IDLE) && !buf_busy && !clear_req;
    grant_char = idle_free && char_valid && (!stat_valid || last_grant_stat);
    grant_stat = idle_free && stat_valid && (!char_valid || !last_grant_stat);
  end

  assign char_ready = grant_char;
  assign stat_ready = grant_stat;

  // Main sequencer: transfer decode, cursor ownership, write strobe and fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      write_enable    <= 1'b0;
      write_x         <= '0;
      write_y         <= '0;
      write_data      <= '0;
      cursor_x        <= '0;
      cursor_y        <= '0;
      clearing        <= 1'b0;
      last_grant_stat <= 1'b1;
      fill_x          <= '0;
      fill_y          <= '0;
      fill_last       <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!buf_busy) begin
            if (clear_req) begin
              clearing  <= 1'b1;
              fill_x    <= '0;
              fill_y    <= '0;
              fill_last <= 1'b0;
              state     <= S_CLEAR;
            end else if (grant_char) begin
              last_grant_stat <= 1'b0;
              case (char_data)
                CH_CR: cursor_x <= '0;
                CH_LF: cursor_y <= (cursor_y == Y_MAX) ? 5'd0 : cursor_y + 5'd1;
                CH_BS: begin
                  // Backspace at column 0 is a no-op.
                  if (cursor_x != 7'd0) begin
                    cursor_x     <= cursor_x - 7'd1;
                    write_x      <= cursor_x - 7'd1;
                    write_y      <= cursor_y;
                    write_data   <= BLANK;
                    write_enable <= 1'b1;
                    state        <= S_ISSUE;
                  end
                end
                CH_FF: begin
                  clearing  <= 1'b1;
                  fill_x    <= '0;
                  fill_y    <= '0;
                  fill_last <= 1'b0;
                  state     <= S_CLEAR;
                end
                default: begin
                  write_x      <= cursor_x;
                  write_y      <= cursor_y;
                  write_data   <= char_data[6:0];
                  write_enable <= 1'b1;
                  state        <= S_ISSUE;
                  // Advance row-major, wrapping the last cell back to (0,0).
                  if (cursor_x == X_MAX) begin
                    cursor_x <= '0;
                    cursor_y <= (cursor_y == Y_MAX) ? 5'd0 : cursor_y + 5'd1;
                  end else begin
                    cursor_x <= cursor_x + 7'd1;
                  end
                end
              endcase
            end else if (grant_stat) begin
              last_grant_stat <= 1'b1;
              // Out-of-range status positions are accepted and dropped.
              if ((stat_x <= X_MAX) && (stat_y <= Y_MAX)) begin
                write_x      <= stat_x;
                write_y      <= stat_y;
                write_data   <= stat_data;
                write_enable <= 1'b1;
                state        <= S_ISSUE;
              end
            end
          end
        end

        S_ISSUE: state <= S_GUARD;

        // GUARD gives the display one cycle to raise busy. If it did not,
        // WAIT would exit immediately anyway, so GUARD returns directly; this
        // lets the next transfer land two cycles after the strobe.
        S_GUARD, S_WAIT: begin
          if (buf_busy) begin
            state <= S_WAIT;
          end else if (!clearing) begin
            state <= S_IDLE;
          end else if (fill_last) begin
            clearing  <= 1'b0;
            fill_last <= 1'b0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            state     <= S_IDLE;
          end else begin
            state <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (!buf_busy) begin
            write_x      <= fill_x;
            write_y      <= fill_y;
            write_data   <= BLANK;
            write_enable <= 1'b1;
            state        <= S_ISSUE;
            fill_last    <= (fill_x == X_MAX) && (fill_y == Y_MAX);
            if (fill_x == X_MAX) begin
              fill_x <= '0;
              fill_y <= (fill_y == Y_MAX) ? 5'd0 : fill_y + 5'd1;
            end else begin
              fill_x <= fill_x + 7'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_write_arbiter.sv
// Testbench for text_write_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a scoreboard model.
module tb_text_write_arbiter;

  localparam int         COLS  = 80;
  localparam int         ROWS  = 30;
  localparam logic [6:0] BLANK = 7'h20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       char_valid, char_ready;
  logic [7:0] char_data;
  logic       stat_valid, stat_ready;
  logic [6:0] stat_x;
  logic [4:0] stat_y;
  logic [6:0] stat_data;
  logic       clear_req, buf_busy;
  logic       write_enable;
  logic [6:0] write_x;
  logic [4:0] write_y;
  logic [6:0] write_data;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       clearing;

  text_write_arbiter #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .reset_n(reset_n),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .stat_valid(stat_valid), .stat_x(stat_x), .stat_y(stat_y),
    .stat_data(stat_data), .stat_ready(stat_ready),
    .clear_req(clear_req), .buf_busy(buf_busy),
    .write_enable(write_enable), .write_x(write_x), .write_y(write_y),
    .write_data(write_data), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .clearing(clearing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         hs;
    int         lat;
    logic       we;
    logic [6:0] wx;
    logic [4:0] wy;
    logic [6:0] wd;
    logic [6:0] cx;
    logic [4:0] cy;
  } res_t;

  // One request: raise valid, wait (bounded) for the handshake, drop valid,
  // then sample the strobe and cursor in the following cycle.
  task automatic apply_req(input bit is_stat, input logic [7:0] cd,
                           input logic [6:0] sx, input logic [4:0] sy,
                           input logic [6:0] sd, output res_t r);
    step();
    if (is_stat) begin
      stat_valid = 1'b1; stat_x = sx; stat_y = sy; stat_data = sd;
    end else begin
      char_valid = 1'b1; char_data = cd;
    end
    r.hs  = 1'b0;
    r.lat = 0;
    for (int i = 0; i < 40 && !r.hs; i++) begin
      @(negedge clk);
      if (is_stat ? stat_ready : char_ready) r.hs = 1'b1;
      else begin r.lat++; step(); end
    end
    step();
    char_valid = 1'b0;
    stat_valid = 1'b0;
    @(negedge clk);
    r.we = write_enable; r.wx = write_x; r.wy = write_y; r.wd = write_data;
    r.cx = cursor_x; r.cy = cursor_y;
  endtask

  task automatic send_char(input logic [7:0] d);
    res_t r;
    apply_req(1'b0, d, 7'd0, 5'd0, 7'd0, r);
    chk("char_handshake", r.hs, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    char_valid = 1'b0; stat_valid = 1'b0; clear_req = 1'b0; buf_busy = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  typedef struct {
    bit         is_stat;
    logic [7:0] cd;
    logic [6:0] sx;
    logic [4:0] sy;
    logic [6:0] sd;
    bit         ewe;
    logic [6:0] ex;
    logic [4:0] ey;
    logic [6:0] ed;
    logic [6:0] ecx;
    logic [4:0] ecy;
  } vec_t;

  vec_t       vt [11];
  res_t       r;
  int         g_kind [4];
  int         g_cyc  [4];
  logic [18:0] wr    [4];
  int         ng, nw, viol, strobes, bad;
  bit         got, done, stat_during;
  logic [18:0] last_w;

  // Scoreboard state for the randomized run
  int          mcx, mcy, lin;
  bit          last_stat;
  logic [18:0] eq [$];
  int          ec [$];
  bit          c_hs, s_hs;
  int          busy_cnt, cerr, perr, rrerr, starv, cw, sw, nhs, rsel;

  task automatic push_write(input int x, input int y, input logic [6:0] d);
    eq.push_back({7'(x), 5'(y), d});
    ec.push_back(cyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 stat  char    sx     sy     sd     we  ex     ey     ed      cx     cy
    vt[0]  = '{1'b0, 8'h0D, 7'd0,  5'd0,  7'h00, 1'b0, 7'd0,  5'd0,  7'h00, 7'd0, 5'd0};
    vt[1]  = '{1'b0, 8'h0A, 7'd0,  5'd0,  7'h00, 1'b0, 7'd0,  5'd0,  7'h00, 7'd0, 5'd1};
    vt[2]  = '{1'b0, 8'h42, 7'd0,  5'd0,  7'h00, 1'b1, 7'd0,  5'd1,  7'h42, 7'd1, 5'd1};
    vt[3]  = '{1'b0, 8'h08, 7'd0,  5'd0,  7'h00, 1'b1, 7'd0,  5'd1,  7'h20, 7'd0, 5'd1};
    vt[4]  = '{1'b0, 8'h08, 7'd0,  5'd0,  7'h00, 1'b0, 7'd0,  5'd0,  7'h00, 7'd0, 5'd1};
    vt[5]  = '{1'b0, 8'hC1, 7'd0,  5'd0,  7'h00, 1'b1, 7'd0,  5'd1,  7'h41, 7'd1, 5'd1};
    vt[6]  = '{1'b1, 8'h00, 7'd10, 5'd2,  7'h53, 1'b1, 7'd10, 5'd2,  7'h53, 7'd1, 5'd1};
    vt[7]  = '{1'b1, 8'h00, 7'd80, 5'd0,  7'h54, 1'b0, 7'd0,  5'd0,  7'h00, 7'd1, 5'd1};
    vt[8]  = '{1'b1, 8'h00, 7'd0,  5'd30, 7'h55, 1'b0, 7'd0,  5'd0,  7'h00, 7'd1, 5'd1};
    vt[9]  = '{1'b1, 8'h00, 7'd79, 5'd29, 7'h5A, 1'b1, 7'd79, 5'd29, 7'h5A, 7'd1, 5'd1};
    vt[10] = '{1'b0, 8'h0A, 7'd0,  5'd0,  7'h00, 1'b0, 7'd0,  5'd0,  7'h00, 7'd1, 5'd2};

    // Reset state, with requests already pending
    reset_n = 1'b0; char_valid = 1'b1; char_data = 8'h41; stat_valid = 1'b1;
    stat_x = 7'd0; stat_y = 5'd0; stat_data = 7'd0; clear_req = 1'b0; buf_busy = 1'b0;
    #12;
    chk("rst_ready", {char_ready, stat_ready}, 2'b00);
    chk("rst_outputs", {write_enable, write_x, write_y, write_data, clearing}, '0);
    chk("rst_cursor", {cursor_x, cursor_y}, '0);
    char_valid = 1'b0; stat_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // First character: immediate ready, strobe next cycle, cursor advances
    apply_req(1'b0, 8'h41, 7'd0, 5'd0, 7'd0, r);
    chk("first_hs", r.hs, 1'b1);
    chk("first_ready_latency", r.lat, 0);
    chk("first_write", {r.we, r.wx, r.wy, r.wd}, {1'b1, 7'd0, 5'd0, 7'h41});
    chk("first_cursor", {r.cx, r.cy}, {7'd1, 5'd0});

    // Vector table: control codes, backspace edges, status range checks
    for (int i = 0; i < 11; i++) begin
      apply_req(vt[i].is_stat, vt[i].cd, vt[i].sx, vt[i].sy, vt[i].sd, r);
      chk($sformatf("vec%0d_hs", i), r.hs, 1'b1);
      if (vt[i].ewe) chk($sformatf("vec%0d_write", i), {r.we, r.wx, r.wy, r.wd},
                         {1'b1, vt[i].ex, vt[i].ey, vt[i].ed});
      else           chk($sformatf("vec%0d_nowrite", i), r.we, 1'b0);
      chk($sformatf("vec%0d_cursor", i), {r.cx, r.cy}, {vt[i].ecx, vt[i].ecy});
    end

    // LF wrap and cursor wrap from the last cell
    do_reset();
    for (int i = 0; i < 29; i++) send_char(8'h0A);
    chk("lf_to_last_row", {cursor_x, cursor_y}, {7'd0, 5'd29});
    send_char(8'h0A);
    chk("lf_wrap", {cursor_x, cursor_y}, {7'd0, 5'd0});
    for (int i = 0; i < 29; i++) send_char(8'h0A);
    for (int i = 0; i < 79; i++) send_char(8'h61);
    chk("cursor_last_cell", {cursor_x, cursor_y}, {7'd79, 5'd29});
    apply_req(1'b0, 8'h42, 7'd0, 5'd0, 7'd0, r);
    chk("last_cell_write", {r.we, r.wx, r.wy, r.wd}, {1'b1, 7'd79, 5'd29, 7'h42});
    chk("last_cell_wrap", {r.cx, r.cy}, {7'd0, 5'd0});
    for (int i = 0; i < 3; i++) send_char(8'h0A);
    for (int i = 0; i < 5; i++) send_char(8'h62);
    chk("cursor_5_3", {cursor_x, cursor_y}, {7'd5, 5'd3});
    apply_req(1'b0, 8'h0D, 7'd0, 5'd0, 7'd0, r);
    chk("cr_nowrite", {r.we, r.cx, r.cy}, {1'b0, 7'd0, 5'd3});
    apply_req(1'b0, 8'h0A, 7'd0, 5'd0, 7'd0, r);
    chk("lf_nowrite", {r.we, r.cx, r.cy}, {1'b0, 7'd0, 5'd4});

    // Round-robin with both requesters held high
    do_reset();
    char_valid = 1'b1; char_data = 8'h78;
    stat_valid = 1'b1; stat_x = 7'd10; stat_y = 5'd2; stat_data = 7'h53;
    ng = 0; nw = 0; viol = 0;
    for (int i = 0; i < 60 && nw < 4; i++) begin
      @(negedge clk);
      if (char_ready && stat_ready) viol++;
      if (char_ready || stat_ready) begin
        if (ng < 4) begin g_kind[ng] = int'(stat_ready); g_cyc[ng] = cyc; end
        ng++;
      end
      if (write_enable) begin
        if (nw < 4) wr[nw] = {write_x, write_y, write_data};
        nw++;
      end
      step();
      if (ng >= 4) begin char_valid = 1'b0; stat_valid = 1'b0; end
    end
    char_valid = 1'b0; stat_valid = 1'b0;
    chk("rr_both_ready", viol, 0);
    chk("rr_writes_seen", nw, 4);
    chk("rr_order", {g_kind[0][0], g_kind[1][0], g_kind[2][0], g_kind[3][0]}, 4'b0101);
    chk("rr_spacing", {8'(g_cyc[1] - g_cyc[0]), 8'(g_cyc[2] - g_cyc[1]), 8'(g_cyc[3] - g_cyc[2])},
        {8'd3, 8'd3, 8'd3});
    chk("rr_w0", wr[0], {7'd0, 5'd0, 7'h78});
    chk("rr_w1", wr[1], {7'd10, 5'd2, 7'h53});
    chk("rr_w2", wr[2], {7'd1, 5'd0, 7'h78});
    chk("rr_w3", wr[3], {7'd10, 5'd2, 7'h53});
    @(negedge clk);
    chk("rr_cursor", {cursor_x, cursor_y}, {7'd2, 5'd0});

    // Display busy for 20 cycles after a strobe blocks the next grant
    apply_req(1'b0, 8'h62, 7'd0, 5'd0, 7'd0, r);
    chk("busy_first_write", {r.we, r.wd}, {1'b1, 7'h62});
    step();
    buf_busy = 1'b1; char_valid = 1'b1; char_data = 8'h63;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (char_ready || write_enable) viol++;
      step();
    end
    buf_busy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (char_ready) got = 1'b1;
      else step();
    end
    chk("busy_blocks", viol, 0);
    chk("busy_release_grant", got, 1'b1);
    step();
    char_valid = 1'b0;
    @(negedge clk);
    chk("busy_second_write", {write_enable, write_x, write_y, write_data},
        {1'b1, 7'd3, 5'd0, 7'h63});

    // Full-screen clear with a status request waiting throughout
    step(); step();
    stat_valid = 1'b1; stat_x = 7'd5; stat_y = 5'd5; stat_data = 7'h51;
    clear_req = 1'b1;
    @(negedge clk);
    chk("clr_start_noready", stat_ready, 1'b0);
    step();
    clear_req = 1'b0;
    @(negedge clk);
    chk("clr_flag", clearing, 1'b1);
    strobes = 0; bad = 0; done = 1'b0; stat_during = 1'b0; last_w = '0;
    for (int i = 0; i < 9000 && !done; i++) begin
      if (write_enable) begin
        if ({write_x, write_y, write_data} !== {7'(strobes % COLS), 5'(strobes / COLS), BLANK}) begin
          if (bad == 0) $display("clear strobe %0d at (%0d,%0d) data 0x%0h", strobes, write_x, write_y, write_data);
          bad++;
        end
        last_w = {write_x, write_y, write_data};
        strobes++;
      end
      if (clearing && stat_ready) stat_during = 1'b1;
      if (!clearing) done = 1'b1;
      else begin step(); @(negedge clk); end
    end
    chk("clr_finished", done, 1'b1);
    chk("clr_strobe_count", strobes, COLS * ROWS);
    chk("clr_order_errors", bad, 0);
    chk("clr_last_cell", last_w, {7'd79, 5'd29, BLANK});
    chk("clr_no_stat_grant", stat_during, 1'b0);
    chk("clr_cursor_home", {cursor_x, cursor_y}, {7'd0, 5'd0});
    got = stat_ready;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      @(negedge clk);
      got = stat_ready;
    end
    chk("clr_stat_after", got, 1'b1);
    step();
    stat_valid = 1'b0;
    @(negedge clk);
    chk("clr_stat_write", {write_enable, write_x, write_y, write_data},
        {1'b1, 7'd5, 5'd5, 7'h51});

    // Reset asserted midway through an FF-triggered clear
    step(); step();
    apply_req(1'b0, 8'h0C, 7'd0, 5'd0, 7'd0, r);
    chk("ff_hs", r.hs, 1'b1);
    chk("ff_clearing", {r.we, clearing}, 2'b01);
    for (int i = 0; i < 300; i++) step();
    char_valid = 1'b1; char_data = 8'h41;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midclr_rst_outputs", {write_enable, write_x, write_y, write_data, clearing}, '0);
    chk("midclr_rst_ready", {char_ready, stat_ready}, 2'b00);
    chk("midclr_rst_cursor", {cursor_x, cursor_y}, '0);
    char_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_enable) viol++;
      step();
    end
    chk("midclr_no_strobe", viol, 0);

    // Reset asserted in the guard cycle after a strobe
    apply_req(1'b0, 8'h67, 7'd0, 5'd0, 7'd0, r);
    chk("guard_write", {r.we, r.wd, r.cx}, {1'b1, 7'h67, 7'd1});
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("guard_rst_outputs", {write_enable, write_x, write_y, write_data, cursor_x, cursor_y}, '0);
    step(); step();
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_enable) viol++;
      step();
    end
    chk("guard_no_strobe", viol, 0);

    // Randomized traffic against the scoreboard
    do_reset();
    mcx = 0; mcy = 0; last_stat = 1'b1;
    c_hs = 1'b0; s_hs = 1'b0; busy_cnt = 0;
    cerr = 0; perr = 0; rrerr = 0; starv = 0; cw = 0; sw = 0; nhs = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (c_hs) char_valid = 1'b0;
      if (s_hs) stat_valid = 1'b0;
      if (i < 2900) begin
        if (!char_valid && $urandom_range(0, 3) == 0) begin
          rsel = $urandom_range(0, 15);
          if (rsel == 0)      char_data = 8'h0D;
          else if (rsel == 1) char_data = 8'h0A;
          else if (rsel < 4)  char_data = 8'h08;
          else                char_data = 8'($urandom_range(32, 255));
          char_valid = 1'b1;
        end
        if (!stat_valid && $urandom_range(0, 4) == 0) begin
          stat_x = 7'($urandom_range(0, 95));
          stat_y = 5'($urandom_range(0, 31));
          stat_data = 7'($urandom_range(0, 127));
          stat_valid = 1'b1;
        end
      end
      if (busy_cnt > 0) begin buf_busy = 1'b1; busy_cnt--; end
      else buf_busy = 1'b0;
      @(negedge clk);
      if (write_enable) begin
        if (eq.size() == 0) chk("rand_unexpected_write", eq.size(), 1);
        else begin
          chk("rand_write", {write_x, write_y, write_data, 8'(cyc - ec[0])}, {eq[0], 8'd1});
          void'(eq.pop_front());
          void'(ec.pop_front());
        end
        busy_cnt = $urandom_range(0, 3);
      end else if (busy_cnt == 0 && $urandom_range(0, 19) == 0) begin
        busy_cnt = $urandom_range(1, 3);
      end
      if ({cursor_x, cursor_y} !== {7'(mcx), 5'(mcy)}) cerr++;
      if (char_ready && stat_ready) perr++;
      if ((char_ready || stat_ready) && buf_busy) perr++;
      if ((char_ready && !char_valid) || (stat_ready && !stat_valid)) perr++;
      c_hs = char_valid && char_ready;
      s_hs = stat_valid && stat_ready;
      if (c_hs) begin
        if (stat_valid && !last_stat) rrerr++;
        last_stat = 1'b0;
        nhs++;
        case (char_data)
          8'h0D: mcx = 0;
          8'h0A: mcy = (mcy + 1) % ROWS;
          8'h08: if (mcx > 0) begin mcx--; push_write(mcx, mcy, BLANK); end
          default: begin
            push_write(mcx, mcy, char_data[6:0]);
            lin = (mcy * COLS + mcx + 1) % (COLS * ROWS);
            mcx = lin % COLS;
            mcy = lin / COLS;
          end
        endcase
      end else if (s_hs) begin
        if (char_valid && last_stat) rrerr++;
        last_stat = 1'b1;
        nhs++;
        if (stat_x < COLS && stat_y < ROWS) push_write(stat_x, stat_y, stat_data);
      end
      if (char_valid && !c_hs) cw++; else cw = 0;
      if (stat_valid && !s_hs) sw++; else sw = 0;
      if (cw == 60 || sw == 60) starv++;
    end
    chk("rand_cursor_errors", cerr, 0);
    chk("rand_ready_errors", perr, 0);
    chk("rand_roundrobin_errors", rrerr, 0);
    chk("rand_starvation", starv, 0);
    chk("rand_pending_writes", eq.size(), 0);
    chk("rand_activity", nhs > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
